// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the two-requester burst arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        XFER     = 2'd2,
        WAIT_ACK = 2'd3
    } arbState_t;

    localparam int BURST_LEN_DEF   = 8;
    localparam int ACK_TIMEOUT_DEF = 255;

    typedef logic [7:0] busByte_t;

    // Everything the arbiter presents downstream, registered as one word.
    typedef struct packed {
        logic     grantA1;
        logic     grantA2;
        logic     readyA1;
        logic     readyA2;
        logic     timeout;
        logic     abort;
        busByte_t bus;
    } arbOut_t;

    // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
    function automatic logic pickA2(input logic reqA1, input logic reqA2, input logic lastA2);
        if (reqA1 && reqA2)
            return ~lastA2;
        return reqA2;
    endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting A1/A2 bursts of BURST_LEN bytes onto a shared 8-bit bus,
// then holding the grant until the collector accepts or the wait times out.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int BURST_LEN   = BURST_LEN_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic       clkArb,
    input  logic       rst,
    input  logic       reqA1,
    input  logic       reqA2,
    input  logic [7:0] dataA1,
    input  logic [7:0] dataA2,
    input  logic       acceptedB,
    output logic       grantA1,
    output logic       grantA2,
    output logic [7:0] sharedBus,
    output logic       readyA1,
    output logic       readyA2,
    output logic       busy,
    output logic       timeout,
    output logic       abort
);

    arbState_t state, nextState;
    logic [3:0] byteCnt;
    logic [7:0] waitCnt;
    logic       lastA2;
    logic       winA2;
    arbOut_t    outD, outQ;

    logic     winReq;
    busByte_t winData;
    logic     lastByte;
    logic     waitExpired;

    assign winReq      = winA2 ? reqA2 : reqA1;
    assign winData     = winA2 ? dataA2 : dataA1;
    assign lastByte    = (byteCnt == 4'(BURST_LEN - 1));
    assign waitExpired = (waitCnt == 8'(ACK_TIMEOUT - 1));

    always_ff @(posedge clkArb) begin
        if (rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (reqA1 || reqA2) nextState = GRANT;
            GRANT:    nextState = winReq ? XFER : IDLE;
            XFER: begin
                if (!winReq)
                    nextState = IDLE;
                else if (lastByte)
                    nextState = WAIT_ACK;
            end
            WAIT_ACK: if (acceptedB || waitExpired) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Outputs are registered from the cycle's state and inputs, so each one
    // shows up one cycle after the condition that produced it.
    always_comb begin
        outD = '0;
        case (state)
            GRANT: begin
                if (winReq) begin
                    outD.grantA1 = ~winA2;
                    outD.grantA2 = winA2;
                end else begin
                    outD.abort = 1'b1;
                end
            end
            XFER: begin
                if (winReq) begin
                    outD.grantA1 = ~winA2;
                    outD.grantA2 = winA2;
                    outD.readyA1 = ~winA2;
                    outD.readyA2 = winA2;
                    outD.bus     = winData;
                end else begin
                    outD.abort = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (!acceptedB && waitExpired) begin
                    outD.timeout = 1'b1;
                end else if (!acceptedB) begin
                    outD.grantA1 = ~winA2;
                    outD.grantA2 = winA2;
                end
            end
            default: outD = '0;
        endcase
    end

    always_ff @(posedge clkArb) begin
        if (rst) begin
            byteCnt <= '0;
            waitCnt <= '0;
            lastA2  <= 1'b1;
            winA2   <= 1'b0;
            outQ    <= '0;
        end else begin
            outQ <= outD;
            if (state == IDLE && (reqA1 || reqA2))
                winA2 <= pickA2(reqA1, reqA2, lastA2);
            byteCnt <= (state == XFER && nextState == XFER) ? byteCnt + 4'd1 : 4'd0;
            waitCnt <= (state == WAIT_ACK && nextState == WAIT_ACK) ? waitCnt + 8'd1 : 8'd0;
            // Only a completed burst (accepted or timed out) moves the pointer; aborts do not.
            if (state == WAIT_ACK && nextState == IDLE)
                lastA2 <= winA2;
        end
    end

    assign grantA1   = outQ.grantA1;
    assign grantA2   = outQ.grantA2;
    assign readyA1   = outQ.readyA1;
    assign readyA2   = outQ.readyA2;
    assign timeout   = outQ.timeout;
    assign abort     = outQ.abort;
    assign sharedBus = outQ.bus;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: bursts, round robin, timeout, abort and mid-burst reset.
module tb_bus_arbiter;

    localparam int BL = 8;

    logic       clkArb = 1'b0;
    logic       rst = 1'b1;
    logic       reqA1 = 1'b0, reqA2 = 1'b0;
    logic [7:0] dataA1 = 8'h00, dataA2 = 8'h00;
    logic       acceptedB = 1'b0;
    logic       grantA1, grantA2, readyA1, readyA2, busy, timeout, abort;
    logic [7:0] sharedBus;

    int nChk = 0;
    int nFail = 0;

    bus_arbiter #(.BURST_LEN(8), .ACK_TIMEOUT(255)) dut (
        .clkArb(clkArb), .rst(rst), .reqA1(reqA1), .reqA2(reqA2),
        .dataA1(dataA1), .dataA2(dataA2), .acceptedB(acceptedB),
        .grantA1(grantA1), .grantA2(grantA2), .sharedBus(sharedBus),
        .readyA1(readyA1), .readyA2(readyA2), .busy(busy),
        .timeout(timeout), .abort(abort)
    );

    always #5 clkArb = ~clkArb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] allOut();
        return {grantA1, grantA2, readyA1, readyA2, busy, timeout, abort, sharedBus};
    endfunction

    // Advance one cycle and sample just after the edge; exclusivity is checked every cycle.
    task automatic step();
        @(posedge clkArb);
        #1;
        chk("excl", {30'd0, grantA1 & grantA2, readyA1 & readyA2}, 32'd0);
    endtask

    task automatic doReset();
        rst = 1'b1; reqA1 = 1'b0; reqA2 = 1'b0; acceptedB = 1'b0;
        step();
        chk("reset.out", allOut(), 0);
        rst = 1'b0;
    endtask

    // Entered in the cycle the request(s) are first presented; returns with the
    // last byte on the bus and the FSM already waiting for acceptedB.
    task automatic doXfer(input logic w, input logic [7:0] base, input logic ackMid);
        step();
        chk("gnt0.busy", busy, 1);
        chk("gnt0.grant", {grantA1, grantA2}, 0);
        step();
        chk("gnt1.grant", {grantA1, grantA2}, w ? 2'b01 : 2'b10);
        chk("gnt1.ready", {readyA1, readyA2}, 0);
        dataA1 = w ? 8'hEE : base;
        dataA2 = w ? base : 8'hEE;
        for (int i = 0; i < BL; i++) begin
            step();
            chk("xfer.ready", {readyA1, readyA2}, w ? 2'b01 : 2'b10);
            chk("xfer.data", sharedBus, 8'(base + i));
            chk("xfer.grant", {grantA1, grantA2}, w ? 2'b01 : 2'b10);
            dataA1 = w ? 8'hEE : 8'(base + i + 1);
            dataA2 = w ? 8'(base + i + 1) : 8'hEE;
            acceptedB = ackMid && (i == 1);
        end
    endtask

    task automatic ackPhase(input logic w, input int waitCycles);
        for (int k = 0; k < waitCycles; k++) begin
            step();
            chk("wait.grant", {grantA1, grantA2}, w ? 2'b01 : 2'b10);
            chk("wait.ready", {readyA1, readyA2}, 0);
            chk("wait.bus", sharedBus, 0);
            chk("wait.busy", busy, 1);
        end
        acceptedB = 1'b1;
        step();
        chk("release.grant", {grantA1, grantA2}, 0);
        chk("release.busy", busy, 0);
        acceptedB = 1'b0;
    endtask

    initial begin
        int seen;

        doReset();

        // Single A1 burst, accept three cycles into the wait
        reqA1 = 1'b1;
        doXfer(1'b0, 8'h11, 1'b0);
        ackPhase(1'b0, 3);
        reqA1 = 1'b0;
        step();
        chk("idle.busy", busy, 0);

        // Both requesting: A1, A2, A1; the A2 burst also sees a stray acceptedB mid-transfer
        doReset();
        reqA1 = 1'b1; reqA2 = 1'b1;
        doXfer(1'b0, 8'h31, 1'b0);
        ackPhase(1'b0, 0);
        doXfer(1'b1, 8'h41, 1'b1);
        ackPhase(1'b1, 1);
        doXfer(1'b0, 8'h51, 1'b0);
        ackPhase(1'b0, 0);
        reqA1 = 1'b0; reqA2 = 1'b0;
        step();

        // A2 drops its request in the 4th transfer cycle
        reqA2 = 1'b1;
        step();
        step();
        chk("ab.grant", {grantA1, grantA2}, 2'b01);
        dataA2 = 8'h21;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ab.ready", readyA2, 1);
            chk("ab.data", sharedBus, 8'(8'h21 + i));
            dataA2 = 8'(8'h22 + i);
        end
        reqA2 = 1'b0;
        step();
        chk("ab.abort", abort, 1);
        chk("ab.ready0", {readyA1, readyA2}, 0);
        chk("ab.grant0", {grantA1, grantA2}, 0);
        chk("ab.busy", busy, 0);
        step();
        chk("ab.pulse", abort, 0);
        // Pointer untouched by the abort: A2 still wins the tie
        reqA1 = 1'b1; reqA2 = 1'b1;
        step();
        step();
        chk("ab.rr", {grantA1, grantA2}, 2'b01);
        reqA1 = 1'b0; reqA2 = 1'b0;
        step();
        chk("ab.abort2", abort, 1);
        step();

        // acceptedB never arrives
        doReset();
        reqA1 = 1'b1;
        doXfer(1'b0, 8'h61, 1'b0);
        seen = -1;
        for (int n = 1; n <= 300; n++) begin
            step();
            if (timeout && seen < 0) begin
                seen = n;
                break;
            end
        end
        chk("to.cycle", 32'(seen), 32'd255);
        chk("to.grant", {grantA1, grantA2}, 0);
        chk("to.busy", busy, 0);
        reqA1 = 1'b0;
        step();
        chk("to.pulse", timeout, 0);
        // Timeout still counts as serving A1
        reqA1 = 1'b1; reqA2 = 1'b1;
        step();
        step();
        chk("to.rr", {grantA1, grantA2}, 2'b01);
        reqA1 = 1'b0; reqA2 = 1'b0;
        step();
        step();

        // Reset in the middle of a transfer, then a normal burst
        doReset();
        reqA1 = 1'b1;
        dataA1 = 8'h99;
        for (int i = 0; i < 5; i++) step();
        chk("rx.preReady", readyA1, 1);
        rst = 1'b1;
        step();
        chk("rx.out", allOut(), 0);
        rst = 1'b0;
        doXfer(1'b0, 8'h71, 1'b0);
        ackPhase(1'b0, 0);
        reqA1 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 8: bytes per granted burst on the 8-bit bus.
REQ-002 Parameter ACK_TIMEOUT, default 255: maximum cycles spent waiting for acceptedB.
REQ-003 clkArb  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 reqA1  input  1  burst request from device A1.
REQ-006 reqA2  input  1  burst request from device A2.
REQ-007 dataA1  input  8  byte source of A1.
REQ-008 dataA2  input  8  byte source of A2.
REQ-009 acceptedB  input  1  downstream collector has taken the assembled 64-bit word.
REQ-010 grantA1  output  1  A1 owns the bus.
REQ-011 grantA2  output  1  A2 owns the bus.
REQ-012 sharedBus  output  8  registered byte presented to the collector.
REQ-013 readyA1  output  1  sharedBus carries a valid A1 byte this cycle.
REQ-014 readyA2  output  1  sharedBus carries a valid A2 byte this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout  output  1  one-cycle pulse when the acceptedB wait expires.
REQ-017 abort  output  1  one-cycle pulse when a burst is aborted.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, GRANT, XFER, WAIT_ACK.
REQ-019 IDLE: if any request is high, select a winner and go to GRANT on the next edge; otherwise stay in IDLE.
REQ-020 Winner selection: a single request wins outright; with both high, the requester not granted last wins (round-robin pointer lastA2).
REQ-021 GRANT: the winner's grant is asserted for one cycle with readyA1/readyA2 low; next state is XFER.
REQ-022 XFER: each cycle, sharedBus is registered from the winner's data and only the winner's readyAx is high; the 4-bit byte counter increments.
REQ-023 XFER lasts exactly BURST_LEN cycles, giving BURST_LEN consecutive ready pulses; after the last byte, the next state is WAIT_ACK and the counter clears.
REQ-024 WAIT_ACK: the grant is held, ready signals are low, and sharedBus is 0; acceptedB high ends the wait.
REQ-025 On acceptedB in WAIT_ACK: release the grant, update lastA2 to the served requester, and go to IDLE; the release is visible on the next cycle.
REQ-026 If acceptedB has not arrived after ACK_TIMEOUT cycles in WAIT_ACK: pulse timeout, release the grant, go to IDLE, and still update lastA2.
REQ-027 If the granted requester drops its request during GRANT or XFER: pulse abort, drive ready low, clear the counter, release the grant, go to IDLE, and leave lastA2 unchanged.
REQ-028 acceptedB is ignored outside WAIT_ACK.
REQ-029 Requests from the non-granted device are ignored until the FSM returns to IDLE.
REQ-030 grantA1 and grantA2 are never high together, and readyA1 and readyA2 are never high together.
REQ-031 From IDLE, the first byte appears 2 cycles after the request is sampled; minimum request-to-release latency is BURST_LEN+3 cycles.

Reset
REQ-032 When rst is high at a rising edge, the state becomes IDLE, counters clear, lastA2 = 1 (A1 favoured first), and all outputs go to 0, including sharedBus = 8'h00.
REQ-033 Reset asserted mid-burst or in WAIT_ACK discards the burst immediately, with no timeout or abort pulse.

Structure
REQ-034 The package bus_arb_pkg SHALL hold the state enum (2 bits), the BURST_LEN and ACK_TIMEOUT defaults, and the 8-bit byte typedef.
REQ-035 The block is a single module with no sub-modules; the timeout counter is 8 bits and is separate from the byte counter.

Verification
REQ-036 Only reqA1 high, dataA1 = 8'h11..8'h18, acceptedB after 3 cycles -> grantA1 only, readyA1 for 8 cycles carrying 11..18, release 1 cycle after acceptedB.
REQ-037 reqA1 and reqA2 high together after reset -> A1 served first; keeping both high, the next burst goes to A2, then A1.
REQ-038 acceptedB never asserted -> timeout pulses once exactly 255 cycles after WAIT_ACK entry, grant is released, and busy falls.
REQ-039 reqA2 dropped at the 4th XFER cycle -> abort pulses, readyA2 stops after 3 bytes, IDLE on the next cycle, and lastA2 is unchanged.
REQ-040 rst pulsed during XFER -> next cycle all outputs are 0 and state is IDLE; after rst falls, an A1 request is granted normally.
REQ-041 acceptedB pulsed during XFER -> no effect; the burst completes all 8 bytes.
